// File: rtl/jedro_1_ifu_pkg.sv
// jedro_1_defines: constants shared by the jedro_1 front end.
//   INSTR_ALIGN_BITS : low address bits that are zero for an aligned instruction
//   INSTR_BYTES      : bytes per instruction word (sequential pc increment)
//   RESET_ADDR       : default boot address of the core
package jedro_1_defines;
    localparam int unsigned INSTR_ALIGN_BITS = 2;
    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_ADDR       = 32'h0000_0000;
endpackage

// File: rtl/jedro_1_ifu_fifo.sv
// jedro_1_ifu_fifo: prefetch FIFO of the instruction fetch unit. Each entry
// holds an instruction word and its byte address.
//   clk_i, rstn_i    : clock, asynchronous active-low reset
//   push_i           : write data_i/addr_i at the tail
//   pop_i            : drop the head entry
//   flush_i          : empty the FIFO (overrides push/pop)
//   data_i, addr_i   : entry to push
//   data_o, addr_o   : head entry (registered storage)
//   count_o          : number of valid entries
module jedro_1_ifu_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic                        flush_i,
    input  logic [DATA_WIDTH-1:0]       data_i,
    input  logic [ADDR_WIDTH-1:0]       addr_i,
    output logic [DATA_WIDTH-1:0]       data_o,
    output logic [ADDR_WIDTH-1:0]       addr_o,
    output logic [$clog2(DEPTH):0]      count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_mem_q[i] <= '0;
                addr_mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i && !flush_i) begin
                data_mem_q[wr_ptr_q] <= data_i;
                addr_mem_q[wr_ptr_q] <= addr_i;
            end
        end
    end

    assign data_o  = data_mem_q[rd_ptr_q];
    assign addr_o  = addr_mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/jedro_1_ifu.sv
// jedro_1_ifu: instruction fetch unit. Holds the pc, prefetches sequential
// words from a 1-cycle-latency ROM into a small FIFO and hands them to the
// decoder over valid/ready. A jump redirects the pc and flushes the FIFO.
//   clk_i, rstn_i        : clock, asynchronous active-low reset
//   jmp_addr_i           : redirect target (low two bits ignored)
//   jmp_addr_valid_i     : redirect request, one-cycle pulse
//   ready_i              : decoder accepts the head instruction
//   valid_o              : instr_o/addr_o hold a fetched instruction
//   instr_o, addr_o      : head instruction word and its byte address
//   imem_en_o            : ROM read enable
//   imem_addr_o          : ROM byte address
//   imem_rdata_i         : ROM data, one cycle after an enabled request
module jedro_1_ifu
    import jedro_1_defines::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = ADDR_WIDTH'(RESET_ADDR),
    parameter int unsigned           FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [ADDR_WIDTH-1:0] jmp_addr_i,
    input  logic                  jmp_addr_valid_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  imem_en_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i
);
    localparam int unsigned           CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((1 << INSTR_ALIGN_BITS) - 1);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  inflight_q, inflight_d;
    logic                  drop_q, drop_d;
    logic [CNT_W-1:0]      count;
    logic [CNT_W:0]        credit_used;
    logic                  issue, push, pop;

    // A request is only issued when a FIFO slot is guaranteed for its
    // response, counting the word still on its way back from the ROM.
    assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
    assign issue       = rstn_i && !jmp_addr_valid_i &&
                         (credit_used < (CNT_W + 1)'(FIFO_DEPTH));

    // A jump wins over any push or pop in the same cycle.
    assign push = inflight_q && !drop_q && !jmp_addr_valid_i;
    assign pop  = valid_o && ready_i && !jmp_addr_valid_i;

    always_comb begin
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        inflight_d = issue;
        drop_d     = 1'b0;
        if (jmp_addr_valid_i) begin
            pc_d   = jmp_addr_i & ALIGN_MASK;
            // Any response still owed by the old stream must not reach the FIFO.
            drop_d = inflight_q;
        end else if (issue) begin
            pc_d       = pc_q + ADDR_WIDTH'(INSTR_BYTES);
            req_addr_d = pc_q;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pc_q       <= BOOT_ADDR;
            req_addr_q <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    jedro_1_ifu_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (jmp_addr_valid_i),
        .data_i  (imem_rdata_i),
        .addr_i  (req_addr_q),
        .data_o  (instr_o),
        .addr_o  (addr_o),
        .count_o (count)
    );

    assign valid_o     = (count != '0);
    assign imem_en_o   = issue;
    assign imem_addr_o = pc_q;
endmodule

// File: tb/tb_jedro_1_ifu.sv
module tb_jedro_1_ifu;
    logic        clk;
    logic        rstn;
    logic [31:0] jmp_addr;
    logic        jmp_v;
    logic        ready;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        en;
    logic [31:0] imem_addr;
    logic [31:0] rdata;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    jedro_1_ifu #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .BOOT_ADDR  (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .jmp_addr_i       (jmp_addr),
        .jmp_addr_valid_i (jmp_v),
        .ready_i          (ready),
        .valid_o          (valid),
        .instr_o          (instr),
        .addr_o           (addr),
        .imem_en_o        (en),
        .imem_addr_o      (imem_addr),
        .imem_rdata_i     (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image: words 0..7 are addi x(i),x0,i; other addresses get a
    // distinct address-derived pattern.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [31:0] i;
        if (a < 32'h20) begin
            i = (a >> 2) + 32'd1;
            return (i << 20) | (i << 7) | 32'h13;
        end
        return {a[31:2], 2'b11} ^ 32'h5A00_0000;
    endfunction

    // ROM with one cycle of read latency.
    initial rdata = 32'h0;
    always @(posedge clk) if (en) rdata <= rom_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted instruction is compared against the scoreboard.
    always @(negedge clk) begin
        if (valid && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer: got addr %h expected no transfer", addr);
            end else begin
                logic [31:0] ea;
                ea = exp_q.pop_front();
                check("xfer_addr", addr, ea);
                check("xfer_instr", instr, rom_word(ea));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Redirect (optionally two back-to-back jumps), then let n words stream.
    task automatic redirect(input logic [31:0] t1, input bit twice, input logic [31:0] t2,
                            input logic [31:0] first, input int n);
        check("q_empty_before_jump", exp_q.size(), 32'd0);
        for (int k = 0; k < n; k++) exp_q.push_back(first + 32'(4 * k));
        ready    = 1'b0;
        jmp_v    = 1'b1;
        jmp_addr = t1;
        #1 check("jump_cycle_no_issue", {31'b0, en}, 32'd1 - 32'd1);
        step();
        if (twice) begin
            jmp_addr = t2;
            #1 check("jump2_cycle_no_issue", {31'b0, en}, 32'd0);
            step();
        end
        jmp_v = 1'b0;
        ready = 1'b1;
        #1;
        check("post_jump_en", {31'b0, en}, 32'd1);
        check("post_jump_imem_addr", imem_addr, first);
        step();
        check("jump_E1_valid", {31'b0, valid}, 32'd0);
        step();
        check("jump_E2_valid", {31'b0, valid}, 32'd1);
        check("jump_E2_addr", addr, first);
        repeat (n) step();
        ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rstn     = 1'b0;
        jmp_v    = 1'b0;
        jmp_addr = 32'h0;
        ready    = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_en", {31'b0, en}, 32'd0);
        check("rst_imem_addr", imem_addr, 32'h0);

        // Sequential stream, decoder always ready: words 0x0..0x1C
        for (int k = 0; k < 8; k++) exp_q.push_back(32'(4 * k));
        ready = 1'b1;
        rstn  = 1'b1;
        #1;
        check("first_fetch_en", {31'b0, en}, 32'd1);
        check("first_fetch_addr", imem_addr, 32'h0);
        step();
        check("startup_E1_valid", {31'b0, valid}, 32'd0);
        step();
        check("startup_E2_valid", {31'b0, valid}, 32'd1);
        check("startup_E2_addr", addr, 32'h0);
        repeat (8) step();
        ready = 1'b0;

        // Back-pressure: FIFO fills with 0x20..0x2C and fetching stops
        check("q_empty_after_stream", exp_q.size(), 32'd0);
        repeat (10) step();
        check("full_en", {31'b0, en}, 32'd0);
        check("full_valid", {31'b0, valid}, 32'd1);
        check("full_head_addr", addr, 32'h20);
        check("full_head_instr", instr, rom_word(32'h20));

        // Pop one word; then three buffered entries plus one in flight
        exp_q.push_back(32'h20);
        ready = 1'b1;
        step();
        ready = 1'b0;
        #1;
        check("refill_en", {31'b0, en}, 32'd1);
        check("refill_imem_addr", imem_addr, 32'h30);
        step();
        check("inflight_blocks_en", {31'b0, en}, 32'd0);

        // Jump with FIFO holding 0x24..0x2C and 0x30 in flight
        redirect(32'h40, 1'b0, 32'h0, 32'h40, 4);
        // Back-to-back jumps: only the last one is fetched
        redirect(32'h80, 1'b1, 32'h100, 32'h100, 2);
        // Misaligned target
        redirect(32'h42, 1'b0, 32'h0, 32'h40, 1);
        // pc wrap-around
        redirect(32'hFFFF_FFFC, 1'b0, 32'h0, 32'hFFFF_FFFC, 2);

        // Reset in the middle of a stream
        check("q_empty_before_reset", exp_q.size(), 32'd0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        ready = 1'b1;
        step();
        step();
        #2 rstn = 1'b0;
        #1;
        check("midrst_valid", {31'b0, valid}, 32'd0);
        check("midrst_en", {31'b0, en}, 32'd0);
        check("midrst_imem_addr", imem_addr, 32'h0);
        check("midrst_q_empty", exp_q.size(), 32'd0);
        step();
        step();
        for (int k = 0; k < 3; k++) exp_q.push_back(32'(4 * k));
        rstn = 1'b1;
        #1;
        check("restart_en", {31'b0, en}, 32'd1);
        check("restart_imem_addr", imem_addr, 32'h0);
        step();
        check("restart_E1_valid", {31'b0, valid}, 32'd0);
        step();
        check("restart_E2_valid", {31'b0, valid}, 32'd1);
        check("restart_E2_addr", addr, 32'h0);
        repeat (3) step();
        ready = 1'b0;
        step();
        check("q_empty_at_end", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
